// File: rtl/pool_engine_if.sv
// -----------------------------------------------------------------------------
// pool_engine_if
//   Valid/ready pixel stream used on both sides of the pooling engine.
//   Each beat carries one pixel, with all channel lanes packed side by side.
//   Lane c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
//
// Signals
//   data   WIDTH bits   packed pixel
//   valid  1            data is valid
//   ready  1            sink accepts the beat this cycle
//
// Modports
//   master  drives data/valid and samples ready (the producer)
//   slave   samples data/valid and drives ready (the consumer)
// -----------------------------------------------------------------------------
interface pool_engine_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pool_engine.sv
// -----------------------------------------------------------------------------
// pool_engine
//   Streaming max-pooling engine. It takes a raster-order feature map with
//   CHANNELS lanes per pixel and emits one pooled pixel for every
//   non-overlapping POOL_SIZE x POOL_SIZE window. The map size is set per run.
//   A horizontal accumulator folds each window row. A one-row line buffer, with
//   one entry per window column, folds those row results vertically.
//
//   Optional feature macro POOL_AVG_EN adds the cfg_mode input, which is
//   latched on start. With cfg_mode=1 the engine averages each window instead
//   of taking its maximum. The average is the window sum shifted right
//   arithmetically by 2*log2(P), so it rounds toward -inf.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start            1-cycle pulse; latches cfg_*; honoured only when idle
//   cfg_width/height input map size in pixels
//   cfg_mode         (POOL_AVG_EN only) 0 = max, 1 = average
//   in_s             slave stream of input pixels
//   out_s            master stream of pooled pixels
//   busy             high while a map is in progress, from start to done
//   done             1-cycle pulse once the map is consumed and drained
// -----------------------------------------------------------------------------
module pool_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int POOL_SIZE  = 2,
  parameter int MAX_IFM_W  = 64,
  parameter int MAX_IFM_H  = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_IFM_W+1)-1:0] cfg_width,
  input  logic [$clog2(MAX_IFM_H+1)-1:0] cfg_height,
`ifdef POOL_AVG_EN
  input  logic                           cfg_mode,
`endif
  pool_engine_if.slave                   in_s,
  pool_engine_if.master                  out_s,
  output logic                           busy,
  output logic                           done
);

  localparam int WW       = $clog2(MAX_IFM_W+1);
  localparam int HW       = $clog2(MAX_IFM_H+1);
  localparam int LOG_P    = $clog2(POOL_SIZE);
  localparam int LB_DEPTH = MAX_IFM_W / POOL_SIZE;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int PW       = CHANNELS * DATA_WIDTH;
`ifdef POOL_AVG_EN
  // Wide enough to hold the sum of a full P*P window without overflow.
  localparam int AW       = DATA_WIDTH + 2*LOG_P;
`else
  localparam int AW       = DATA_WIDTH;
`endif
  localparam int LW       = CHANNELS * AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   x_q, x_d, w_q, w_d, wlim_q, wlim_d;
  logic [HW-1:0]   y_q, y_d, h_q, h_d, hlim_q, hlim_d;
`ifdef POOL_AVG_EN
  logic            mode_q, mode_d;
`endif
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic [LW-1:0]   acc_q, acc_d, acc_ld;

  // Line buffer. It is written and read at the same address, the window column
  // of the current x. The read is registered.
  logic [LW-1:0]   lbuf [LB_DEPTH];
  logic [LW-1:0]   lb_rd_q;
  logic [LW-1:0]   lb_wdata;
  logic [LBW-1:0]  lb_addr;
  logic [PW-1:0]   pool_vec;

  logic            in_ready, accept, win_end, emit, lb_we, row_end, last_px;
  logic [LOG_P-1:0] px, py;

`ifdef POOL_AVG_EN
  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b,
                                                   input logic avg);
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] finish(input logic signed [AW-1:0] v,
                                                   input logic avg);
    logic signed [AW-1:0] t;
    t = avg ? (v >>> (2*LOG_P)) : v;
    return t[DATA_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    return (a > b) ? a : b;
  endfunction
`endif

  // Stream control. A new pixel is taken only when the output slot is free or
  // is emptying this cycle. This keeps a completed window from overwriting an
  // unaccepted result.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_s.ready);
  assign accept   = in_ready && in_s.valid;

  // POOL_SIZE is a power of two, so the low bits of x and y give the position
  // inside the window.
  assign px      = x_q[LOG_P-1:0];
  assign py      = y_q[LOG_P-1:0];
  assign lb_addr = LBW'(x_q >> LOG_P);

  // Trailing columns and rows beyond the last whole window are consumed, but
  // they never touch the line buffer or the output.
  assign win_end = accept && (&px) && (x_q < wlim_q) && (y_q < hlim_q);
  assign emit    = win_end && (&py);
  assign lb_we   = win_end && !(&py);
  assign row_end = (x_q + WW'(1)) == w_q;
  assign last_px = row_end && ((y_q + HW'(1)) == h_q);

  // Per-lane datapath.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] pix_raw;
    logic signed [AW-1:0]         pix, acc, lb_rd, h, fin;

    assign pix_raw = in_s.data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign pix     = AW'(pix_raw);
    assign acc     = acc_q[gi*AW +: AW];
    assign lb_rd   = lb_rd_q[gi*AW +: AW];
`ifdef POOL_AVG_EN
    assign h   = combine(acc, pix, mode_q);
    assign fin = combine(lb_rd, h, mode_q);
    assign pool_vec[gi*DATA_WIDTH +: DATA_WIDTH] = finish(fin, mode_q);
`else
    assign h   = combine(acc, pix);
    assign fin = combine(lb_rd, h);
    assign pool_vec[gi*DATA_WIDTH +: DATA_WIDTH] = fin;
`endif
    // The first column of a window row loads the pixel. Later columns fold it in.
    assign acc_ld[gi*AW +: AW]   = (px == '0) ? pix : h;
    // The first window row seeds the buffer entry. Later rows fold into it.
    assign lb_wdata[gi*AW +: AW] = (py == '0) ? h : fin;
  end

  assign acc_d = accept ? acc_ld : acc_q;

  // Control FSM and raster counters.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    wlim_d  = wlim_q;
    hlim_d  = hlim_q;
`ifdef POOL_AVG_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d    = cfg_width;
          h_d    = cfg_height;
          wlim_d = cfg_width  & ~WW'(POOL_SIZE-1);
          hlim_d = cfg_height & ~HW'(POOL_SIZE-1);
          x_d    = '0;
          y_d    = '0;
`ifdef POOL_AVG_EN
          mode_d = cfg_mode;
`endif
          // A map smaller than one window has nothing to pool, so finish at once.
          state_d = (cfg_width >= WW'(POOL_SIZE) && cfg_height >= HW'(POOL_SIZE))
                    ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (row_end) begin
            x_d = '0;
            y_d = y_q + HW'(1);
          end else begin
            x_d = x_q + WW'(1);
          end
          if (last_px) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_s.ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register. It holds its value until the downstream accepts it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_s.ready) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = pool_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      wlim_q      <= '0;
      hlim_q      <= '0;
`ifdef POOL_AVG_EN
      mode_q      <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      wlim_q      <= wlim_d;
      hlim_q      <= hlim_d;
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
    end
  end

  // Line buffer storage. The registered read is always one cycle late, and
  // that is safe. By the time the last column of a window arrives, the
  // address has been on the entry of that window for at least one cycle. Any
  // earlier write to that entry (from a previous window row) happened before
  // that cycle. A write only occurs on the last column of a window, and the
  // address moves on right after it, so no stale read can occur.
  always_ff @(posedge clk) begin
    if (lb_we) lbuf[lb_addr] <= lb_wdata;
    lb_rd_q <= lbuf[lb_addr];
  end

  assign in_s.ready  = in_ready;
  assign out_s.valid = out_valid_q;
  assign out_s.data  = out_data_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_engine.sv
`timescale 1ns/1ps
module tb_pool_engine;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int P  = 2;
  localparam int MW = 64;
  localparam int MH = 64;
  localparam int PW = DW * CH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] cfg_width = '0;
  logic [6:0] cfg_height = '0;
`ifdef POOL_AVG_EN
  logic       cfg_mode = 1'b0;
`endif
  logic       busy, done;

  pool_engine_if #(.WIDTH(PW)) in_if ();
  pool_engine_if #(.WIDTH(PW)) out_if ();

  pool_engine #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .POOL_SIZE(P), .MAX_IFM_W(MW), .MAX_IFM_H(MH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef POOL_AVG_EN
    .cfg_mode   (cfg_mode),
`endif
    .in_s       (in_if),
    .out_s      (out_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mp [MH][MW][CH];          // feature map under test, signed element values
  logic [PW-1:0] got_q [$];     // outputs accepted during the last run

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_random(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        for (int c = 0; c < CH; c++)
          mp[y][x][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  function automatic logic [PW-1:0] pack_pixel(input int x, input int y);
    logic [PW-1:0] p;
    int t;
    p = '0;
    for (int c = 0; c < CH; c++) begin
      t = mp[y][x][c];
      p[c*DW +: DW] = t[DW-1:0];
    end
    return p;
  endfunction

  // Reference result of window (wx, wy): the maximum, or the floor of the mean.
  function automatic logic [PW-1:0] model_win(input int wx, input int wy, input int mode);
    logic [PW-1:0] r;
    int m, s, v, e;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      m = -1000;
      s = 0;
      for (int dy = 0; dy < P; dy++)
        for (int dx = 0; dx < P; dx++) begin
          e = mp[wy*P+dy][wx*P+dx][c];
          if (e > m) m = e;
          s += e;
        end
      if (mode == 0) v = m;
      else begin
        v = s / (P*P);
        if ((s % (P*P) != 0) && (s < 0)) v--;
      end
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  // rdy_mode: 0 = out_ready always 1, 1 = random, 2 = stall 10 cycles on the
  // first output. abort_cyc > 0 stops the run early, in the middle of the map.
  task automatic run_map(input int w, input int h, input int mode,
                         input int rdy_mode, input int abort_cyc);
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] held;
    int  n_in, exp_in, dones, bp_left, n_out, x, y;
    bit  pend, pend_n, completes, finished, armed, post;
    held = '0;
    exp_in = (w >= P && h >= P) ? w*h : 0;
    for (int wy = 0; wy < h/P; wy++)
      for (int wx = 0; wx < w/P; wx++)
        exp_q.push_back(model_win(wx, wy, mode));
    got_q.delete();
    n_in = 0; dones = 0; bp_left = 0; n_out = 0;
    pend = 1'b0; finished = 1'b0; post = 1'b0; armed = (rdy_mode == 2);
    $display("map %0dx%0d mode=%0d rdy_mode=%0d expecting %0d outputs", w, h, mode, rdy_mode, exp_q.size());

    @(negedge clk);
    cfg_width  = 7'(w);
    cfg_height = 7'(h);
`ifdef POOL_AVG_EN
    cfg_mode   = mode[0];
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Once start is accepted, the cfg inputs must no longer matter.
    cfg_width  = 7'($urandom_range(0, 64));
    cfg_height = 7'($urandom_range(0, 64));

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (abort_cyc > 0 && cyc == abort_cyc) break;
      in_if.valid = (n_in < w*h) && ($urandom_range(0, 3) != 0);
      if (in_if.valid) in_if.data = pack_pixel(n_in % w, n_in / w);
      else             in_if.data = PW'($urandom);
      case (rdy_mode)
        0:       out_if.ready = 1'b1;
        1:       out_if.ready = 1'($urandom_range(0, 1));
        default: out_if.ready = !(armed || bp_left > 0);
      endcase
      // A start pulse in the middle of a map must be ignored.
      start = (cyc == 3) && (dones == 0);
      #1;

      if (post) begin
        chk("done_width", 64'(done), 64'(0));
        chk("idle_after_done", 64'(busy), 64'(0));
        finished = 1'b1;
      end
      chk("out_valid_timing", 64'(out_if.valid), 64'(pend));
      if (dones == 0 && done !== 1'b1) chk("busy", 64'(busy), 64'(1));

      if (rdy_mode == 2) begin
        if (bp_left > 0) begin
          chk("bp_in_ready", 64'(in_if.ready), 64'(0));
          chk("bp_data_stable", 64'(out_if.data), 64'(held));
          bp_left--;
        end else if (armed && out_if.valid) begin
          armed   = 1'b0;
          held    = out_if.data;
          bp_left = 10;
        end
      end

      completes = 1'b0;
      if (in_if.valid && in_if.ready) begin
        x = n_in % w;
        y = n_in / w;
        completes = (x % P == P-1) && (y % P == P-1) && (x < (w/P)*P) && (y < (h/P)*P);
        n_in++;
      end

      pend_n = pend;
      if (out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) chk("output_expected", 64'(0), 64'(1));
        else chk($sformatf("out_data#%0d", n_out), 64'(out_if.data), 64'(exp_q.pop_front()));
        $display("out #%0d map %0dx%0d data=%h", n_out, w, h, out_if.data);
        got_q.push_back(out_if.data);
        n_out++;
        pend_n = 1'b0;
      end
      if (completes) pend_n = 1'b1;

      if (done === 1'b1 && !post) begin
        dones++;
        chk("done_inputs", 64'(n_in), 64'(exp_in));
        chk("done_outputs_left", 64'(exp_q.size()), 64'(0));
        post = 1'b1;
      end
      pend = pend_n;
      start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    in_if.valid = 1'b0;
    if (abort_cyc == 0) begin
      chk("done_pulse_count", 64'(dones), 64'(1));
      chk("outputs_all", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ramp [4];
    logic [7:0] e8;
    exp_ramp = '{5, 7, 13, 15};
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_if.ready), 64'(0));
    chk("rst_out_valid", 64'(out_if.valid), 64'(0));
    chk("rst_out_data", 64'(out_if.data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 ramp on lane 0
    fill_random(4, 4);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        mp[y][x][0] = y*4 + x;
    run_map(4, 4, 0, 0, 0);
    chk("ramp_count", 64'(got_q.size()), 64'(4));
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("ramp_lane0_%0d", i), 64'(got_q[i][7:0]), 64'(exp_ramp[i]));

    // Signed 2x2 window
    fill_random(2, 2);
    mp[0][0][0] = -128; mp[0][1][0] = -1; mp[1][0][0] = -7; mp[1][1][0] = -100;
    run_map(2, 2, 0, 1, 0);
    chk("signed_count", 64'(got_q.size()), 64'(1));
    e8 = 8'hFF;
    if (got_q.size() > 0) chk("signed_max", 64'(got_q[0][7:0]), 64'(e8));

    // Trailing column and row dropped
    fill_random(5, 3);
    run_map(5, 3, 0, 1, 0);
    chk("5x3_count", 64'(got_q.size()), 64'(2));

    // Back-pressure
    fill_random(8, 4);
    run_map(8, 4, 0, 2, 0);
    chk("bp_count", 64'(got_q.size()), 64'(8));

    // Maps too small for a window
    run_map(1, 5, 0, 1, 0);
    run_map(6, 1, 0, 1, 0);

    // Full-width line buffer
    fill_random(64, 4);
    run_map(64, 4, 0, 1, 0);

    // Random sizes
    for (int k = 0; k < 4; k++) begin
      int w, h;
      w = int'($urandom_range(2, 13));
      h = int'($urandom_range(2, 9));
      fill_random(w, h);
      run_map(w, h, 0, 1, 0);
    end

    // Reset in the middle of a map, then a clean restart
    fill_random(8, 8);
    run_map(8, 8, 0, 1, 30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_if.ready), 64'(0));
    chk("midrst_out_valid", 64'(out_if.valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(6, 6);
    run_map(6, 6, 0, 1, 0);

`ifdef POOL_AVG_EN
    fill_random(2, 2);
    mp[0][0][0] = 4; mp[0][1][0] = 5; mp[1][0][0] = 6; mp[1][1][0] = 8;
    run_map(2, 2, 1, 1, 0);
    e8 = 8'd5;
    if (got_q.size() > 0) chk("avg_pos", 64'(got_q[0][7:0]), 64'(e8));
    fill_random(2, 2);
    mp[0][0][0] = -1; mp[0][1][0] = -2; mp[1][0][0] = -2; mp[1][1][0] = -2;
    run_map(2, 2, 1, 1, 0);
    e8 = 8'hFE;
    if (got_q.size() > 0) chk("avg_neg", 64'(got_q[0][7:0]), 64'(e8));
    fill_random(6, 4);
    run_map(6, 4, 1, 1, 0);
    fill_random(4, 4);
    run_map(4, 4, 0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
